// File: rtl/dmem_pkg.sv
// Shared definitions for the dmem responder: default geometry, fill FSM
// states and the byte-mask merge used by both the write and forward paths.
package dmem_pkg;

  localparam int DMEM_DATA_W  = 32;
  localparam int DMEM_ADDR_W  = 8;
  localparam int DMEM_DEPTH   = 256;
  // Widest word the merge helper handles; callers cast in and out.
  localparam int DMEM_MERGE_W = 256;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } fill_state_e;

  // Replace each byte of old_w whose mask bit is set with the same byte of new_w.
  function automatic logic [DMEM_MERGE_W-1:0] mask_merge(
    input logic [DMEM_MERGE_W-1:0]   old_w,
    input logic [DMEM_MERGE_W-1:0]   new_w,
    input logic [DMEM_MERGE_W/8-1:0] mask
  );
    logic [DMEM_MERGE_W-1:0] res;
    res = old_w;
    for (int k = 0; k < DMEM_MERGE_W/8; k++)
      if (mask[k]) res[8*k +: 8] = new_w[8*k +: 8];
    return res;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem port bundle between the core (master) and the SRAM responder (slave).
interface dmem_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);

  logic                  dmem_csb_write_i;
  logic [DATA_W/8-1:0]   dmem_wmask_i;
  logic [ADDR_W-1:0]     dmem_waddr_i;
  logic [DATA_W-1:0]     dmem_din_i;
  logic                  dmem_csb_read_i;
  logic [ADDR_W-1:0]     dmem_raddr_i;
  logic [DATA_W-1:0]     dmem_dout_o;
  logic                  dout_valid_o;
  logic                  ready_o;
  logic                  oob_o;

  modport master (
    output dmem_csb_write_i, dmem_wmask_i, dmem_waddr_i, dmem_din_i,
    output dmem_csb_read_i, dmem_raddr_i,
    input  dmem_dout_o, dout_valid_o, ready_o, oob_o
  );

  modport slave (
    input  dmem_csb_write_i, dmem_wmask_i, dmem_waddr_i, dmem_din_i,
    input  dmem_csb_read_i, dmem_raddr_i,
    output dmem_dout_o, dout_valid_o, ready_o, oob_o
  );

endinterface

// File: rtl/dmem_read_pipe.sv
// Fixed-latency read return pipe. Each stage's data only loads when a valid
// read moves into it, so the last stage holds the most recent completed read.
module dmem_read_pipe #(
  parameter int DATA_W = 32,
  parameter int STAGES = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data
);

  logic [STAGES-1:0]             vld_pipe;
  logic [STAGES-1:0][DATA_W-1:0] data_pipe;

  // Shift valid every cycle; data follows only alongside a valid bit.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      vld_pipe  <= '0;
      data_pipe <= '0;
    end else begin
      for (int s = STAGES-1; s >= 1; s--) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) data_pipe[s] <= data_pipe[s-1];
      end
      vld_pipe[0] <= in_vld;
      if (in_vld) data_pipe[0] <= in_data;
    end
  end

  assign out_vld  = vld_pipe[STAGES-1];
  assign out_data = data_pipe[STAGES-1];

endmodule

// File: rtl/dmem_responder.sv
// Synchronous word-addressed SRAM model on the core's dmem port. Zero-fills
// after reset, then serves byte-masked writes and fixed-latency reads.
// Optional macro DMEM_RESPONDER_FORWARD_EN: a same-address read/write in one
// cycle returns the newly written bytes (write-first) instead of the old word.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W       = DMEM_DATA_W,
  parameter int ADDR_W       = DMEM_ADDR_W,
  parameter int DEPTH        = DMEM_DEPTH,
  parameter int READ_LATENCY = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  dmem_responder_if.slave  bus
);

  localparam int MASK_W = DATA_W/8;
  localparam int IDX_W  = $clog2(DEPTH);

  fill_state_e           state, state_nxt;
  logic [IDX_W-1:0]      cnt, cnt_nxt;
  logic [DATA_W-1:0]     mem [DEPTH];

  logic                  run;
  logic                  wr_go, rd_go, wr_inb, rd_inb, wr_en;
  logic [IDX_W-1:0]      widx, ridx;
  logic [DATA_W-1:0]     rd_word, wr_word, rd_data;
  logic                  oob;

  function automatic logic [DATA_W-1:0] merge(
    input logic [DATA_W-1:0] o,
    input logic [DATA_W-1:0] n,
    input logic [MASK_W-1:0] m
  );
    return DATA_W'(mask_merge(DMEM_MERGE_W'(o), DMEM_MERGE_W'(n), (DMEM_MERGE_W/8)'(m)));
  endfunction

  assign run    = (state == RUN);
  // Strobes are only honoured in RUN and never in a reset cycle.
  assign wr_go  = reset_i && run && !bus.dmem_csb_write_i;
  assign rd_go  = reset_i && run && !bus.dmem_csb_read_i;
  assign wr_inb = 32'(bus.dmem_waddr_i) < DEPTH;
  assign rd_inb = 32'(bus.dmem_raddr_i) < DEPTH;
  assign wr_en  = wr_go && wr_inb;
  assign widx   = bus.dmem_waddr_i[IDX_W-1:0];
  assign ridx   = bus.dmem_raddr_i[IDX_W-1:0];

  assign rd_word = rd_inb ? mem[ridx] : '0;
  assign wr_word = merge(mem[widx], bus.dmem_din_i, bus.dmem_wmask_i);

`ifdef DMEM_RESPONDER_FORWARD_EN
  // Write-first: a colliding read sees the bytes being written this cycle.
  always_comb begin
    rd_data = rd_word;
    if (wr_en && rd_inb && (bus.dmem_waddr_i == bus.dmem_raddr_i))
      rd_data = merge(rd_word, bus.dmem_din_i, bus.dmem_wmask_i);
  end
`else
  assign rd_data = rd_word;
`endif

  // Fill FSM state and counter.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state <= FILL;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Fill walks every word once, then parks in RUN until the next reset.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      FILL: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == IDX_W'(DEPTH-1)) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      default: ;
    endcase
  end

  // Storage: zero during fill, byte-masked core writes in RUN.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      if (state == FILL) mem[cnt] <= '0;
      else if (wr_en)    mem[widx] <= wr_word;
    end
  end

  // One pulse per cycle with any out-of-range access, even if both ports miss.
  always_ff @(posedge clk_i) begin
    if (!reset_i) oob <= 1'b0;
    else          oob <= (rd_go && !rd_inb) || (wr_go && !wr_inb);
  end

  dmem_read_pipe #(
    .DATA_W (DATA_W),
    .STAGES (READ_LATENCY)
  ) u_read_pipe (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .in_vld   (rd_go),
    .in_data  (rd_data),
    .out_vld  (bus.dout_valid_o),
    .out_data (bus.dmem_dout_o)
  );

  assign bus.ready_o = run;
  assign bus.oob_o   = oob;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances with different geometry/latency
// share one stimulus stream and are compared against a behavioural model.
module tb_dmem_responder;

  localparam int NDUT = 3;

  function automatic int dep(input int k);
    return (k == 1) ? 200 : 256;
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 2;
  endfunction

  logic        clk = 1'b0;
  logic        rst_n [NDUT];
  logic        csb_w = 1'b1, csb_r = 1'b1;
  logic [3:0]  wmask = '0;
  logic [7:0]  waddr = '0, raddr = '0;
  logic [31:0] din = '0;

  logic [31:0] dout [NDUT];
  logic        vld  [NDUT];
  logic        rdy  [NDUT];
  logic        oob  [NDUT];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    dmem_responder_if #(.DATA_W(32), .ADDR_W(8)) bus ();
    assign bus.dmem_csb_write_i = csb_w;
    assign bus.dmem_wmask_i     = wmask;
    assign bus.dmem_waddr_i     = waddr;
    assign bus.dmem_din_i       = din;
    assign bus.dmem_csb_read_i  = csb_r;
    assign bus.dmem_raddr_i     = raddr;
    assign dout[k] = bus.dmem_dout_o;
    assign vld[k]  = bus.dout_valid_o;
    assign rdy[k]  = bus.ready_o;
    assign oob[k]  = bus.oob_o;
    dmem_responder #(
      .DATA_W(32), .ADDR_W(8), .DEPTH(dep(k)), .READ_LATENCY(lat(k))
    ) u_dut (
      .clk_i   (clk),
      .reset_i (rst_n[k]),
      .bus     (bus)
    );
  end

  // ---------------- reference model ----------------
  logic [31:0] mm [NDUT][256];
  int          fcnt [NDUT];
  int          cyc  [NDUT];
  logic [7:0]  sv   [NDUT];       // scheduled result slots, indexed by edge mod 8
  logic [31:0] sd   [NDUT][8];
  logic        m_rdy [NDUT], m_vld [NDUT], m_oob [NDUT];
  logic [31:0] m_dout [NDUT];

  task automatic model_edge();
    logic [31:0] old, d;
    logic rd, wr, rin, win;
    int slot;
    for (int k = 0; k < NDUT; k++) begin
      if (!rst_n[k]) begin
        sv[k] = '0; fcnt[k] = 0; cyc[k] = 0;
        m_rdy[k] = 0; m_vld[k] = 0; m_oob[k] = 0; m_dout[k] = '0;
      end else begin
        cyc[k]++;
        m_oob[k] = 0;
        if (!m_rdy[k]) begin
          mm[k][fcnt[k]] = '0;
          fcnt[k]++;
          if (fcnt[k] == dep(k)) m_rdy[k] = 1;
        end else begin
          rd  = !csb_r;
          wr  = !csb_w;
          rin = int'(raddr) < dep(k);
          win = int'(waddr) < dep(k);
          old = rin ? mm[k][raddr] : 32'h0;
          if (wr && win)
            for (int b = 0; b < 4; b++)
              if (wmask[b]) mm[k][waddr][8*b +: 8] = din[8*b +: 8];
          d = old;
`ifdef DMEM_RESPONDER_FORWARD_EN
          if (rd && rin && wr && win && raddr == waddr) d = mm[k][raddr];
`endif
          if (rd) begin
            slot = (cyc[k] + lat(k) - 1) % 8;
            sv[k][slot] = 1'b1;
            sd[k][slot] = d;
          end
          m_oob[k] = (rd && !rin) || (wr && !win);
        end
        slot = cyc[k] % 8;
        m_vld[k] = sv[k][slot];
        if (sv[k][slot]) m_dout[k] = sd[k][slot];
        sv[k][slot] = 1'b0;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csb_w = 1'b1;
    csb_r = 1'b1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
    csb_w = 1'b0; waddr = a; din = d; wmask = m;
  endtask

  task automatic do_read(input logic [7:0] a);
    csb_r = 1'b0; raddr = a;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int k = 0; k < NDUT; k++) rst_n[k] = 1'b0;
    idle();
    repeat (3) step();
    for (int k = 0; k < NDUT; k++) begin
      total++; if (dout[k] !== 32'h0) begin bad++; $display("FAIL reset_dout[%0d]: got %h want 0", k, dout[k]); end
      total++; if (vld[k]  !== 1'b0)  begin bad++; $display("FAIL reset_vld[%0d]: got %b want 0", k, vld[k]); end
      total++; if (rdy[k]  !== 1'b0)  begin bad++; $display("FAIL reset_rdy[%0d]: got %b want 0", k, rdy[k]); end
      total++; if (oob[k]  !== 1'b0)  begin bad++; $display("FAIL reset_oob[%0d]: got %b want 0", k, oob[k]); end
    end
  endtask

  task automatic test_fill();
    int first [NDUT];
    for (int k = 0; k < NDUT; k++) begin rst_n[k] = 1'b1; first[k] = 0; end
    for (int n = 1; n <= 300; n++) begin
      step();
      for (int k = 0; k < NDUT; k++) if (rdy[k] === 1'b1 && first[k] == 0) first[k] = n;
    end
    for (int k = 0; k < NDUT; k++) begin
      total++;
      if (first[k] != dep(k)) begin bad++; $display("FAIL fill_ready[%0d]: rose after %0d cycles want %0d", k, first[k], dep(k)); end
    end
    do_read(8'h7F);
    step();
    idle();
    total++; if (vld[0] !== 1'b1)     begin bad++; $display("FAIL fill_read_vld: got %b want 1", vld[0]); end
    total++; if (dout[0] !== 32'h0)   begin bad++; $display("FAIL fill_read_data: got %h want 0", dout[0]); end
  endtask

  task automatic test_masked_write();
    do_write(8'h10, 32'hDEADBEEF, 4'hF); step();
    do_write(8'h10, 32'h000000AA, 4'h1); step();
    idle(); do_write(8'h11, 32'h55555555, 4'h0); step();   // zero mask writes nothing
    idle(); do_read(8'h10); step();
    idle();
    total++; if (vld[0] !== 1'b1)          begin bad++; $display("FAIL mask_vld: got %b want 1", vld[0]); end
    total++; if (dout[0] !== 32'hDEADBEAA) begin bad++; $display("FAIL mask_data: got %h want deadbeaa", dout[0]); end
    do_read(8'h11); step(); idle();
    total++; if (dout[0] !== 32'h0)        begin bad++; $display("FAIL mask_zero: got %h want 0", dout[0]); end
    step();
    total++; if (vld[0] !== 1'b0 || dout[0] !== 32'h0) begin bad++; $display("FAIL hold: got vld=%b dout=%h want 0/0", vld[0], dout[0]); end
  endtask

  task automatic test_collision();
    logic [31:0] exp_d;
`ifdef DMEM_RESPONDER_FORWARD_EN
    exp_d = 32'h22222222;
`else
    exp_d = 32'h11111111;
`endif
    do_write(8'h20, 32'h11111111, 4'hF); step();
    do_write(8'h20, 32'h22222222, 4'hF); do_read(8'h20); step();
    idle();
    total++; if (vld[0] !== 1'b1 || dout[0] !== exp_d) begin bad++; $display("FAIL collide: got vld=%b dout=%h want 1/%h", vld[0], dout[0], exp_d); end
    do_read(8'h20); step(); idle();
    total++; if (dout[0] !== 32'h22222222) begin bad++; $display("FAIL collide_after: got %h want 22222222", dout[0]); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin do_write(8'(i), 32'hA0 + i, 4'hF); step(); end
    idle();
    for (int t = 1; t <= 8; t++) begin
      if (t <= 4) do_read(8'(t - 1)); else idle();
      step();
      total++;
      if (vld[1] !== (t >= 3 && t <= 6)) begin bad++; $display("FAIL b2b_vld t=%0d: got %b want %b", t, vld[1], (t >= 3 && t <= 6)); end
      if (t >= 3 && t <= 6) begin
        total++;
        if (dout[1] !== 32'hA0 + (t - 3)) begin bad++; $display("FAIL b2b_data t=%0d: got %h want %h", t, dout[1], 32'hA0 + (t - 3)); end
      end
    end
  endtask

  task automatic test_oob();
    do_write(8'hC7, 32'h12345678, 4'hF); step();
    do_write(8'hC8, 32'hFFFFFFFF, 4'hF); step(); idle();
    total++; if (oob[1] !== 1'b1 || oob[0] !== 1'b0) begin bad++; $display("FAIL oob_wr: got u1=%b u0=%b want 1/0", oob[1], oob[0]); end
    step();
    total++; if (oob[1] !== 1'b0) begin bad++; $display("FAIL oob_clear: got %b want 0", oob[1]); end
    do_read(8'hC8); step();
    total++; if (oob[1] !== 1'b1) begin bad++; $display("FAIL oob_rd: got %b want 1", oob[1]); end
    do_read(8'hC7); step(); idle();
    total++; if (oob[1] !== 1'b0) begin bad++; $display("FAIL oob_inb_rd: got %b want 0", oob[1]); end
    step();
    total++; if (vld[1] !== 1'b1 || dout[1] !== 32'h0) begin bad++; $display("FAIL oob_rdata: got vld=%b dout=%h want 1/0", vld[1], dout[1]); end
    step();
    total++; if (vld[1] !== 1'b1 || dout[1] !== 32'h12345678) begin bad++; $display("FAIL oob_neighbour: got vld=%b dout=%h want 1/12345678", vld[1], dout[1]); end
    do_write(8'hF0, 32'h1, 4'hF); do_read(8'hF1); step(); idle();
    total++; if (oob[1] !== 1'b1) begin bad++; $display("FAIL oob_both: got %b want 1", oob[1]); end
    step();
    total++; if (oob[1] !== 1'b0) begin bad++; $display("FAIL oob_both_single: got %b want 0", oob[1]); end
    repeat (3) step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      csb_w = 1'($urandom_range(0, 1));
      csb_r = 1'($urandom_range(0, 1));
      wmask = 4'($urandom_range(0, 15));
      din   = $urandom;
      waddr = 8'($urandom_range(0, 255));
      raddr = (n % 4 == 0) ? waddr : 8'($urandom_range(0, 255));
      step();
      for (int k = 0; k < NDUT; k++) begin
        total++;
        if (vld[k] !== m_vld[k] || dout[k] !== m_dout[k] || oob[k] !== m_oob[k] || rdy[k] !== m_rdy[k]) begin
          bad++;
          $display("FAIL rand[%0d] n=%0d: got v=%b d=%h o=%b r=%b want v=%b d=%h o=%b r=%b",
                   k, n, vld[k], dout[k], oob[k], rdy[k], m_vld[k], m_dout[k], m_oob[k], m_rdy[k]);
        end
      end
    end
    idle();
    repeat (4) step();
  endtask

  task automatic test_reset_mid_read();
    int first;
    first = 0;
    do_read(8'h05); step(); idle();
    total++; if (vld[0] !== 1'b1) begin bad++; $display("FAIL midrst_u0_vld: got %b want 1", vld[0]); end
    rst_n[2] = 1'b0; step(); rst_n[2] = 1'b1;
    total++; if (rdy[2] !== 1'b0 || vld[2] !== 1'b0) begin bad++; $display("FAIL midrst_state: got rdy=%b vld=%b want 0/0", rdy[2], vld[2]); end
    for (int n = 1; n <= 300; n++) begin
      step();
      if (n <= 4) begin
        total++;
        if (vld[2] !== 1'b0) begin bad++; $display("FAIL midrst_no_vld n=%0d: got %b want 0", n, vld[2]); end
      end
      if (rdy[2] === 1'b1 && first == 0) first = n;
    end
    total++; if (first != 256) begin bad++; $display("FAIL midrst_refill: rose after %0d want 256", first); end
  endtask

  initial begin
    for (int k = 0; k < NDUT; k++) rst_n[k] = 1'b0;
    test_reset();
    test_fill();
    test_masked_write();
    test_collision();
    test_back_to_back();
    test_oob();
    test_random();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder side of the core's dmem port: a synchronous word-addressed SRAM model. It accepts the core's active-low chip-select write/read strobes, applies byte-masked writes, and returns read data after a fixed pipeline latency.
- After reset it runs a zero-fill sequence and holds ready_o low until the fill finishes.
- Sits at top level beside the core and replaces the external SRAM macro in simulation and FPGA builds.

Parameters:
- DATA_W, 32, data word width; must be a multiple of 8.
- ADDR_W, 8, word-address width.
- DEPTH, 256, number of words; must be ≤ 2^ADDR_W.
- READ_LATENCY, 1, cycles from accepted read to valid dmem_dout_o; legal range 1..4.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  synchronous reset, active-low (asserted when 0).
- dmem_csb_write_i  in  1  write strobe, active-low.
- dmem_wmask_i  in  DATA_W/8  byte enables; bit k covers data bits [8k+7:8k].
- dmem_waddr_i  in  ADDR_W  write word address.
- dmem_din_i  in  DATA_W  write data.
- dmem_csb_read_i  in  1  read strobe, active-low.
- dmem_raddr_i  in  ADDR_W  read word address.
- dmem_dout_o  out  DATA_W  read data.
- dout_valid_o  out  1  marks the cycle in which dmem_dout_o carries the result of a read.
- ready_o  out  1  high once zero-fill is complete.
- oob_o  out  1  one-cycle pulse when an accepted access has an address ≥ DEPTH.

Behaviour:
- Reset (reset_i==0 at a clock edge):
  - dmem_dout_o=0, dout_valid_o=0, ready_o=0, oob_o=0.
  - Read pipeline flushed; fill counter=0; FSM enters FILL.
  - Reset asserted mid-operation has the same effect: any in-flight read is discarded and no dout_valid_o pulse is produced for it.
- FSM states:
  - FILL: writes 0 to word[cnt] each cycle, cnt++. When cnt==DEPTH-1 is written, the next state is RUN. Fill takes exactly DEPTH cycles.
  - RUN: ready_o=1. Stays in RUN until reset.
- During FILL, the core strobes are ignored: no write, no read, no oob_o.
- Write in RUN: when dmem_csb_write_i==0 and waddr<DEPTH, word[waddr] byte k := din byte k for each set wmask bit; unset bytes keep their value. A wmask of 0 writes nothing.
- Read in RUN: when dmem_csb_read_i==0 and raddr<DEPTH, the word is sampled at that edge. dmem_dout_o and dout_valid_o are presented READ_LATENCY cycles later:
  - READ_LATENCY=1: visible on the cycle after the strobe (SRAM style).
  - Back-to-back reads are accepted every cycle; the pipeline has no stalls.
- dmem_dout_o holds its last value when no read completes; dout_valid_o=0 in those cycles.
- Out of bounds (address ≥ DEPTH, strobe active, RUN):
  - Write is dropped.
  - Read returns 0 with dout_valid_o=1 at the normal latency.
  - oob_o pulses for one cycle, registered, on the cycle after the strobe.
  - A simultaneous out-of-bounds read and write produce a single oob_o pulse.
- Same-cycle read and write to the same address: the read returns the pre-write (old) word by default.
- Same-cycle read and write to different addresses: both proceed independently.
- Address arithmetic: unsigned compare against DEPTH; no address wrap.

Optional Feature:
- Macro DMEM_RESPONDER_FORWARD_EN.
- Defined: on a same-address read/write collision, the read result is the old word with the masked bytes replaced by din, i.e. write-first behaviour.
- Undefined: read-first; the read returns the old word.
- No other behaviour changes.

Decomposition:
- Shared package dmem_pkg:
  - DMEM_DATA_W, DMEM_ADDR_W, DMEM_DEPTH constants.
  - The fill-FSM state typedef {FILL, RUN}.
  - A function that merges bytes by mask, reused by the write path and the forwarding logic.
- One natural sub-module, dmem_read_pipe: a READ_LATENCY-deep shift register of {valid, data}, reset to zero.

Test Plan:
- Fill: release reset, DEPTH=256 → ready_o rises exactly 256 cycles after release; a read of address 0x7F returns 0x00000000 with dout_valid_o one cycle later.
- Masked write: write 0xDEADBEEF, mask 0xF to address 0x10, then 0x000000AA, mask 0x1 to address 0x10 → read of address 0x10 returns 0xDEADBEAA.
- Collision: word[0x20]=0x11111111; same-cycle write of 0x22222222 (mask 0xF) and read of address 0x20 → read returns 0x11111111 without the macro, 0x22222222 with it; a later read returns 0x22222222.
- Latency/throughput: READ_LATENCY=3, reads of 0,1,2,3 on consecutive cycles → four consecutive dout_valid_o cycles starting 3 cycles after the first strobe, in order.
- OOB: DEPTH=200, write to address 0xC8, then read of address 0xC8 → oob_o pulses once per access; the read data is 0; word[0xC7] is unchanged.
- Reset mid-read: READ_LATENCY=2, read strobe, reset asserted on the next cycle → no dout_valid_o pulse; ready_o=0 and the fill restarts.
